pulse_led_array: RTL and testbench
==================================

// Module: pulse_led_array
// PURPOSE
//  Multi-channel PWM LED driver; successor to the single-LED breathing pulser.
//  Drives CHANNELS LEDs from one shared prescaled PWM counter.
//  Each channel has its own duty ramp, with a per-channel phase offset.
//  Run-time mode select: off / steady on / breathe (triangle) / sawtooth.
//  Adds enable, synchronous restart and a sweep-complete strobe. Sits on board-level status LEDs.
// PARAMETERS
//  CHANNELS  4     number of LED outputs (1..16)
//  PWM_BITS  8     PWM resolution; PWM period = 2**PWM_BITS ticks; MAX = 2**PWM_BITS-1
//  PRESCALE  1953  clk cycles per PWM tick (>=1)
//  STEP      8     duty increment/decrement per PWM period (1..MAX)
// PORTS
//  clk         in   1         system clock, all logic on posedge
//  rst         in   1         asynchronous, active-high reset
//  en          in   1         1 = run; 0 = freeze all counters/ramps, all LEDs forced off
//  restart     in   1         sync pulse: reload counters and phase offsets (as after reset)
//  mode        in   2         00 OFF, 01 ON, 10 BREATHE, 11 SAW
//  led         out  CHANNELS  registered LED drive, bit n = channel n
//  cycle_done  out  1         1-clk strobe when channel 0 completes a full sweep
// BEHAVIOUR
//  Reset (async, rst=1): pre_cnt=0, pwm_cnt=0, led=0, cycle_done=0, dir[n]=up.
//   Initial duty: duty[n] = (n * 2**PWM_BITS / CHANNELS) truncated to PWM_BITS bits.
//  restart=1 (sync, en-independent): same values as reset, loaded on that edge; has priority over all.
//  Prescaler: pre_cnt counts 0..PRESCALE-1; tick = (pre_cnt==PRESCALE-1) & en.
//  PWM counter: pwm_cnt += 1 on tick, wraps MAX->0.
//   period_end = tick & (pwm_cnt==MAX).
//  Duty update (per channel, only on period_end, only in BREATHE/SAW):
//   Arithmetic in PWM_BITS+1 bits; no wrap-around in BREATHE.
//   BREATHE up:   duty+STEP; if result > MAX, duty=MAX and dir<=down.
//   BREATHE down: if duty <= STEP, duty=0 and dir<=up; else duty-STEP.
//   SAW: if duty > MAX-STEP, duty=0; else duty+STEP. dir unchanged.
//   OFF/ON: duty and dir hold.
//  Output (registered, 1 clk after pwm_cnt/duty/mode/en change):
//   en=0 -> 0; OFF -> 0; ON -> 1; BREATHE/SAW -> (pwm_cnt < duty[n]).
//   duty=0 gives fully off; duty=MAX gives on for MAX of every 2**PWM_BITS ticks.
//  cycle_done: 1 on the clk after a period_end where channel 0 does one of:
//   BREATHE: dir goes down->up (duty reaches 0);  SAW: duty wraps to 0.
//   Otherwise 0.
//  Mode change: output mapping switches on the next clk.
//   Ramps continue from their current duty/dir at the next period_end; no reload.
//  en 1->0: state frozen mid-period; en 0->1 resumes from frozen pre_cnt/pwm_cnt.
//  Simultaneous restart & period_end: restart wins, no duty step, no cycle_done.
// STRUCTURE
//  Shared package pulse_led_pkg:
//   MODE_OFF/MODE_ON/MODE_BREATHE/MODE_SAW (2-bit localparams); DIR_UP/DIR_DOWN.
//  Top: prescaler, pwm_cnt, generate loop of CHANNELS instances, cycle_done register.
//  Sub-module pulse_led_chan (params PWM_BITS, STEP, INIT_DUTY).
//   Holds duty/dir/led for one channel.
//   Inputs: clk, rst, restart, en, period_end, mode, pwm_cnt.
//   Exposes wrap strobe for channel 0.
// TESTING (bench params CHANNELS=2, PWM_BITS=4, PRESCALE=2, STEP=4; period = 32 clk)
//  1 Reset: assert rst mid-run -> led=00, cycle_done=0 immediately; after release duty0=0, duty1=8, dir=up.
//  2 BREATHE: duty0 per period 0,4,8,12,15,11,7,3,0,4.
//     led[0] high for exactly duty0 of 16 ticks each period; cycle_done once, at the 3->0 step.
//  3 SAW: duty0 0,4,8,12,0; duty1 8,12,0,4,8.
//     cycle_done pulses once per 4 periods, at the 12->0 wrap.
//  4 mode=OFF then ON mid-period -> led=00 then 11 on next clk.
//     Back to BREATHE: ramp resumes at unchanged duty.
//  5 en=0 for 50 clk mid-period -> led=00, pwm_cnt/duty hold.
//     en=1 -> sequence continues with no skipped or repeated step.
//  6 restart coinciding with period_end -> duties reload to 0/8, no step taken, cycle_done=0.

Source files
------------

// File: rtl/pulse_led_pkg.sv
// Shared constants for the multi-channel PWM LED driver: mode encodings,
// ramp direction values and the per-channel starting duty.
package pulse_led_pkg;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_ON      = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_SAW     = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Channels start evenly spread around the duty range; caller truncates.
    function automatic int unsigned init_duty(input int unsigned n,
                                              input int unsigned channels,
                                              input int unsigned pwm_bits);
        return (n << pwm_bits) / channels;
    endfunction

endpackage

// File: rtl/pulse_led_chan.sv
// One LED channel: duty ramp (breathe or sawtooth), ramp direction and the
// registered LED compare against the shared PWM counter.
module pulse_led_chan
    import pulse_led_pkg::*;
#(
    parameter int                  PWM_BITS  = 8,
    parameter int                  STEP      = 8,
    parameter logic [PWM_BITS-1:0] INIT_DUTY = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                restart,
    input  logic                en,
    input  logic                period_end,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                wrap
);

    localparam logic [PWM_BITS:0] MAX_W  = (PWM_BITS+1)'((1 << PWM_BITS) - 1);
    localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS+1)'(STEP);

    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_q, dir_d;
    logic                led_q, led_d;
    logic [PWM_BITS:0]   duty_w, sum_w, diff_w;

    always_comb begin
        duty_w = {1'b0, duty_q};
        sum_w  = duty_w + STEP_W;
        diff_w = duty_w - STEP_W;
        duty_d = duty_q;
        dir_d  = dir_q;
        wrap   = 1'b0;
        led_d  = 1'b0;

        if (period_end && !restart) begin
            if (mode == MODE_BREATHE) begin
                if (dir_q == DIR_UP) begin
                    if (sum_w > MAX_W) begin
                        duty_d = MAX_W[PWM_BITS-1:0];
                        dir_d  = DIR_DOWN;
                    end else begin
                        duty_d = sum_w[PWM_BITS-1:0];
                    end
                end else if (duty_w <= STEP_W) begin
                    duty_d = '0;
                    dir_d  = DIR_UP;
                    wrap   = 1'b1;
                end else begin
                    duty_d = diff_w[PWM_BITS-1:0];
                end
            end else if (mode == MODE_SAW) begin
                if (duty_w > MAX_W - STEP_W) begin
                    duty_d = '0;
                    wrap   = 1'b1;
                end else begin
                    duty_d = sum_w[PWM_BITS-1:0];
                end
            end
        end

        if (en) begin
            case (mode)
                MODE_ON:               led_d = 1'b1;
                MODE_BREATHE, MODE_SAW: led_d = (pwm_cnt < duty_q);
                default:               led_d = 1'b0;
            endcase
        end

        // Restart behaves exactly like reset, taking priority over any step.
        if (restart) begin
            duty_d = INIT_DUTY;
            dir_d  = DIR_UP;
            led_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= INIT_DUTY;
            dir_q  <= DIR_UP;
            led_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/pulse_led_array.sv
// Multi-channel PWM LED driver: shared prescaler and PWM counter feeding
// CHANNELS independent duty ramps, plus a sweep-complete strobe from channel 0.
module pulse_led_array
    import pulse_led_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 1953,
    parameter int STEP     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                restart,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] led,
    output logic                cycle_done
);

    localparam int                  PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
    localparam logic [CHANNELS-1:0] WRAP_SEL = CHANNELS'(1);

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                cycle_done_q, cycle_done_d;
    logic                tick, period_end;
    logic [CHANNELS-1:0] wrap;

    always_comb begin
        tick       = (pre_cnt_q == PRE_LAST) && en;
        period_end = tick && (pwm_cnt_q == PWM_MAX);
        pre_cnt_d  = pre_cnt_q;
        pwm_cnt_d  = pwm_cnt_q;

        if (restart) begin
            pre_cnt_d = '0;
            pwm_cnt_d = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
            pwm_cnt_d = pwm_cnt_q + 1'b1;
        end else if (en) begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end

        // Only channel 0 defines a completed sweep.
        cycle_done_d = !restart && |(wrap & WRAP_SEL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q    <= '0;
            pwm_cnt_q    <= '0;
            cycle_done_q <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : gen_chan
        pulse_led_chan #(
            .PWM_BITS  (PWM_BITS),
            .STEP      (STEP),
            .INIT_DUTY (PWM_BITS'(init_duty(n, CHANNELS, PWM_BITS)))
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .restart    (restart),
            .en         (en),
            .period_end (period_end),
            .mode       (mode),
            .pwm_cnt    (pwm_cnt_q),
            .led        (led[n]),
            .wrap       (wrap[n])
        );
    end

    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_pulse_led_array.sv
// Directed bench for pulse_led_array with CHANNELS=2, PWM_BITS=4, PRESCALE=2,
// STEP=4 (one PWM period = 32 clk); duty is inferred from LED high time.
module tb_pulse_led_array;
    import pulse_led_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       restart;
    logic [1:0] mode;
    logic [1:0] led;
    logic       cycle_done;

    int tests_run    = 0;
    int tests_failed = 0;

    int br_duty0 [10] = '{0, 4, 8, 12, 15, 11, 7, 3, 0, 4};
    int br_duty1 [10] = '{8, 12, 15, 11, 7, 3, 0, 4, 8, 12};
    int br_cd    [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int saw_duty0 [8] = '{0, 4, 8, 12, 0, 4, 8, 12};
    int saw_duty1 [8] = '{8, 12, 0, 4, 8, 12, 0, 4};
    int saw_cd    [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

    pulse_led_array #(
        .CHANNELS (2),
        .PWM_BITS (4),
        .PRESCALE (2),
        .STEP     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .restart    (restart),
        .mode       (mode),
        .led        (led),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en_i, input logic restart_i, input logic [1:0] mode_i);
        en      = en_i;
        restart = restart_i;
        mode    = mode_i;
    endtask

    // Sample n falling edges, accumulating LED high samples and strobes.
    task automatic measureWindow(input int n, output int hi0, output int hi1, output int cd);
        hi0 = 0;
        hi1 = 0;
        cd  = 0;
        repeat (n) begin
            @(negedge clk);
            hi0 += int'(led[0]);
            hi1 += int'(led[1]);
            cd  += int'(cycle_done);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int h0, h1, cd;

        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, MODE_ON);
        #2;
        checkOutput("reset_led", led, 0);
        checkOutput("reset_cycle_done", cycle_done, 0);

        // Run in ON, then assert reset asynchronously mid-run.
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("on_before_reset", led, 3);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_led", led, 0);
        checkOutput("async_reset_cycle_done", cycle_done, 0);
        applyStimulus(1'b1, 1'b0, MODE_BREATHE);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            measureWindow(32, h0, h1, cd);
            checkOutput($sformatf("breathe_duty0_p%0d", i), h0, 2 * br_duty0[i]);
            checkOutput($sformatf("breathe_duty1_p%0d", i), h1, 2 * br_duty1[i]);
            checkOutput($sformatf("breathe_cd_p%0d", i), cd, br_cd[i]);
        end

        applyStimulus(1'b1, 1'b1, MODE_SAW);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, MODE_SAW);
        checkOutput("restart_led", led, 0);
        for (int i = 0; i < 8; i++) begin
            measureWindow(32, h0, h1, cd);
            checkOutput($sformatf("saw_duty0_p%0d", i), h0, 2 * saw_duty0[i]);
            checkOutput($sformatf("saw_duty1_p%0d", i), h1, 2 * saw_duty1[i]);
            checkOutput($sformatf("saw_cd_p%0d", i), cd, saw_cd[i]);
        end

        // Mode changes mid-period, holding ON across one period boundary.
        applyStimulus(1'b1, 1'b1, MODE_BREATHE);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, MODE_BREATHE);
        measureWindow(64, h0, h1, cd);
        checkOutput("mode_pre_windows", h0, 8);
        measureWindow(10, h0, h1, cd);
        checkOutput("mode_pre_partial", h0, 10);
        applyStimulus(1'b1, 1'b0, MODE_OFF);
        @(negedge clk);
        checkOutput("mode_off_led", led, 0);
        applyStimulus(1'b1, 1'b0, MODE_ON);
        @(negedge clk);
        checkOutput("mode_on_led", led, 3);
        measureWindow(36, h0, h1, cd);
        applyStimulus(1'b1, 1'b0, MODE_BREATHE);
        measureWindow(16, h0, h1, cd);
        checkOutput("mode_duty_held", h0, 0);
        measureWindow(32, h0, h1, cd);
        checkOutput("mode_resume_p4", h0, 24);
        measureWindow(32, h0, h1, cd);
        checkOutput("mode_resume_p5", h0, 30);

        // Freeze with en=0 for 50 clk in the middle of the duty=11 period.
        measureWindow(10, h0, h1, cd);
        checkOutput("en_pre_freeze", h0, 10);
        applyStimulus(1'b0, 1'b0, MODE_BREATHE);
        measureWindow(50, h0, h1, cd);
        checkOutput("en_off_led", h0 + h1, 0);
        applyStimulus(1'b1, 1'b0, MODE_BREATHE);
        measureWindow(22, h0, h1, cd);
        checkOutput("en_resume_rest", h0, 12);
        measureWindow(32, h0, h1, cd);
        checkOutput("en_next_period", h0, 14);

        // Restart on the very edge where channel 0 would step 3->0 and strobe.
        measureWindow(31, h0, h1, cd);
        checkOutput("restart_pre_edge", h0, 6);
        applyStimulus(1'b1, 1'b1, MODE_BREATHE);
        @(negedge clk);
        checkOutput("restart_edge_cd", cycle_done, 0);
        checkOutput("restart_edge_led", led, 0);
        applyStimulus(1'b1, 1'b0, MODE_BREATHE);
        measureWindow(32, h0, h1, cd);
        checkOutput("restart_duty0_p0", h0, 0);
        checkOutput("restart_duty1_p0", h1, 16);
        checkOutput("restart_cd_p0", cd, 0);
        measureWindow(32, h0, h1, cd);
        checkOutput("restart_duty0_p1", h0, 8);
        checkOutput("restart_duty1_p1", h1, 24);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
